// File: rtl/prog_loader.sv
// Program loader: streams instruction words into instruction memory, then releases the CPU.
// Optional running XOR checksum of loaded words is enabled by defining PROG_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for load_start, CPU held
// LOAD  | accepting words, writing imem one cycle after acceptance
// RUN   | program loaded, CPU released until cpu_halt_req
// ERR   | empty program or overflow, waits for a new load_start
module prog_loader #(
   parameter int INSTR_W = 16,
   parameter int ADDR_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_start,
   input  logic [INSTR_W-1:0] din,
   input  logic               din_valid,
   output logic               din_ready,
   input  logic               load_done,
   input  logic               cpu_halt_req,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_run,
   output logic [ADDR_W:0]    word_count,
   output logic               load_err,
   output logic [INSTR_W-1:0] checksum
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ERR} state_t;

   localparam logic [ADDR_W:0] WORD_CAP = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [INSTR_W-1:0]  wdata_q, wdata_d;
   logic                accept;
   logic                clear_sess;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      accept     = 1'b0;
      clear_sess = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               state_d    = S_LOAD;
               clear_sess = 1'b1;
            end
         end
         S_LOAD: begin
            // a restart wins over everything else arriving in the same cycle
            if (load_start) begin
               clear_sess = 1'b1;
            end else if (din_valid && (count_q == WORD_CAP)) begin
               state_d = S_ERR;
            end else begin
               accept = din_valid;
               if (accept) begin
                  we_d    = 1'b1;
                  addr_d  = count_q[ADDR_W-1:0];
                  wdata_d = din;
                  count_d = count_q + ONE;
               end
               if (load_done) begin
                  state_d = ((count_q != '0) || accept) ? S_RUN : S_ERR;
               end
            end
         end
         S_RUN: begin
            if (cpu_halt_req) state_d = S_IDLE;
         end
         S_ERR: begin
            if (load_start) begin
               state_d    = S_LOAD;
               clear_sess = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (clear_sess) count_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [INSTR_W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clear_sess) sum_d = '0;
      else if (accept) sum_d = sum_q ^ din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_q <= '0;
      else        sum_q <= sum_d;
   end

   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif

   assign din_ready  = (state_q == S_LOAD);
   assign cpu_run    = (state_q == S_RUN);
   assign load_err   = (state_q == S_ERR);
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign word_count = count_q;

endmodule
